// File: rtl/tdm_pkg.sv
// Shared definitions for the tdm_mux4 gather path and its downstream demux.
package tdm_pkg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SELW = 2;
  localparam int unsigned CNTW = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Channel index 'off' slots after ptr, wrapping modulo NCH.
  function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] ptr, input int unsigned off);
    return SELW'(ptr + SELW'(off));
  endfunction

endpackage

// File: rtl/tdm_mux4_if.sv
// Four-channel gather-side input streams plus the merged output stream.
interface tdm_mux4_if #(
  parameter int unsigned WIDTH = 8
);
  import tdm_pkg::*;

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter; search starts one past ptr.
module rr_arb4
  import tdm_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx
);

  always_comb begin
    logic            found;
    logic [SELW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= NCH; off++) begin
      idx = rr_idx(ptr, off);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_mux4.sv
// 4-channel round-robin TDM gather into one registered output beat.
// Optional per-channel accepted-beat counters: define TDM_MUX4_BEAT_CNT_EN.
module tdm_mux4
  import tdm_pkg::SELW, tdm_pkg::CNTW, tdm_pkg::state_t, tdm_pkg::ST_EMPTY, tdm_pkg::ST_FULL;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  tdm_mux4_if.slave  bus
`ifdef TDM_MUX4_BEAT_CNT_EN
  ,
  output logic [CNTW-1:0] beat_cnt0,
  output logic [CNTW-1:0] beat_cnt1,
  output logic [CNTW-1:0] beat_cnt2,
  output logic [CNTW-1:0] beat_cnt3
`endif
);

  if (NCH != tdm_pkg::NCH) begin : g_nch_check
    $error("tdm_mux4: NCH must be 4");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   ptr_q, ptr_d;

  logic              slot_free_c;
  logic [NCH-1:0]    req_c;
  logic [NCH-1:0]    gnt_c;
  logic [SELW-1:0]   gnt_idx_c;
  logic              grant_c;

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

  // Requests are masked while in reset so in_ready stays low there.
  assign slot_free_c = !bus.out_valid || bus.out_ready;
  assign req_c       = bus.in_valid & {NCH{enable && slot_free_c && rst_n}};

  rr_arb4 u_arb (
    .req     (req_c),
    .ptr     (ptr_q),
    .gnt     (gnt_c),
    .gnt_idx (gnt_idx_c)
  );

  assign bus.in_ready = gnt_c;
  assign grant_c      = |gnt_c;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (grant_c) begin
      state_d = ST_FULL;
      sel_d   = gnt_idx_c;
      ptr_d   = gnt_idx_c;
      for (int unsigned k = 0; k < NCH; k++) begin
        if (gnt_c[k]) data_d = bus.in_data[k*WIDTH +: WIDTH];
      end
    end else if ((state_q == ST_FULL) && bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= SELW'(NCH - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef TDM_MUX4_BEAT_CNT_EN
  logic [CNTW-1:0] cnt_q [NCH];

  // Saturating count of accepted input handshakes per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NCH; k++) cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (bus.in_valid[k] && gnt_c[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + CNTW'(1);
      end
    end
  end

  assign beat_cnt0 = cnt_q[0];
  assign beat_cnt1 = cnt_q[1];
  assign beat_cnt2 = cnt_q[2];
  assign beat_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_tdm_mux4.sv
// Directed + random bench for tdm_mux4 with a beat scoreboard and grant model.
module tb_tdm_mux4;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;

  int total = 0;
  int bad = 0;

  beat_t sb[$];
  logic       m_valid = 1'b0;
  int         m_ptr = 3;
  int         m_cnt [4] = '{0, 0, 0, 0};

  tdm_mux4_if #(.WIDTH(WIDTH)) bus ();

`ifdef TDM_MUX4_BEAT_CNT_EN
  logic [15:0] beat_cnt0, beat_cnt1, beat_cnt2, beat_cnt3;
`endif

  tdm_mux4 #(.WIDTH(WIDTH), .NCH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus)
`ifdef TDM_MUX4_BEAT_CNT_EN
    ,
    .beat_cnt0 (beat_cnt0),
    .beat_cnt1 (beat_cnt1),
    .beat_cnt2 (beat_cnt2),
    .beat_cnt3 (beat_cnt3)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_valid = 1'b0;
    m_ptr   = 3;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  // Drive one cycle, check at the falling edge, then advance the model.
  task automatic cyc(input logic en, input logic [3:0] v, input logic ordy);
    int         g;
    logic [3:0] er;
    beat_t      b;
    enable = en;
    bus.in_valid = v;
    bus.out_ready = ordy;
    @(negedge clk);
    g  = -1;
    er = 4'b0000;
    if (rst_n && en && (!m_valid || ordy)) begin
      for (int o = 1; o <= 4; o++) begin
        int k;
        k = (m_ptr + o) % 4;
        if (g < 0 && v[k]) g = k;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'(0), 32'(1));
      end else begin
        chk("out_sel", 32'(bus.out_sel), 32'(sb[0].sel));
        chk("out_data", 32'(bus.out_data), 32'(sb[0].data));
        if (ordy) void'(sb.pop_front());
      end
    end
    if (g >= 0) begin
      b.sel  = 2'(g);
      b.data = bus.in_data[g*WIDTH +: WIDTH];
      sb.push_back(b);
      m_ptr = g;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end
    m_valid = (g >= 0) || (m_valid && !ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    enable        = 1'b1;

    // Reset state with requests pending
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_sel", 32'(bus.out_sel), 32'(0));
    chk("rst_out_data", 32'(bus.out_data), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
    model_reset();
    rst_n = 1'b1;

    // Round-robin with all channels valid
    cyc(1'b1, 4'b1111, 1'b1);
    chk("first_sel", 32'(bus.out_sel), 32'(0));
    chk("first_data", 32'(bus.out_data), 32'(8'hA0));
    repeat (7) cyc(1'b1, 4'b1111, 1'b1);

    // Backpressure while holding channel 2
    guard = 0;
    while (!(m_valid && sb.size() > 0 && sb[0].sel == 2'd2) && guard < 8) begin
      cyc(1'b1, 4'b1111, 1'b1);
      guard++;
    end
    chk("bp_reach_ch2", 32'(guard < 8), 32'(1));
    repeat (5) begin
      cyc(1'b1, 4'b1111, 1'b0);
      chk("bp_hold_sel", 32'(bus.out_sel), 32'(2));
      chk("bp_hold_data", 32'(bus.out_data), 32'(8'hA2));
    end
    cyc(1'b1, 4'b1111, 1'b1);
    chk("bp_next_sel", 32'(bus.out_sel), 32'(3));

    // Enable gating: hold, drain, then re-enable
    cyc(1'b0, 4'b0101, 1'b0);
    cyc(1'b0, 4'b0101, 1'b1);
    cyc(1'b0, 4'b0101, 1'b1);
    chk("en_drained", 32'(bus.out_valid), 32'(0));
    cyc(1'b1, 4'b0101, 1'b1);
    cyc(1'b1, 4'b0101, 1'b1);
    cyc(1'b1, 4'b0101, 1'b1);

    // Single requester on channel 3, pointer wrap without bubbles
    repeat (6) begin
      cyc(1'b1, 4'b1000, 1'b1);
      chk("single_valid", 32'(bus.out_valid), 32'(1));
      chk("single_sel", 32'(bus.out_sel), 32'(3));
    end

    // Asynchronous reset while a beat is held
    cyc(1'b1, 4'b0110, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'(0));
    chk("async_out_sel", 32'(bus.out_sel), 32'(0));
    chk("async_in_ready", 32'(bus.in_ready), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 4'b1111, 1'b1);
    chk("post_rst_sel", 32'(bus.out_sel), 32'(0));
    repeat (4) cyc(1'b1, 4'b1111, 1'b1);

    // Random traffic
    repeat (300) begin
      bus.in_data = $urandom;
      cyc(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    bus.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    repeat (3) cyc(1'b1, 4'b0000, 1'b1);
    chk("final_drain", 32'(bus.out_valid), 32'(0));

`ifdef TDM_MUX4_BEAT_CNT_EN
    do_reset();
    repeat (10) cyc(1'b1, 4'b0010, 1'b1);
    chk("cnt1_10", 32'(beat_cnt1), 32'(10));
    chk("cnt0_0", 32'(beat_cnt0), 32'(0));
    chk("cnt2_0", 32'(beat_cnt2), 32'(0));
    chk("cnt3_0", 32'(beat_cnt3), 32'(0));
    chk("cnt1_model", 32'(beat_cnt1), 32'(m_cnt[1]));
    repeat (65535) cyc(1'b1, 4'b0001, 1'b1);
    chk("cnt0_max", 32'(beat_cnt0), 32'(16'hFFFF));
    cyc(1'b1, 4'b0001, 1'b1);
    chk("cnt0_sat", 32'(beat_cnt0), 32'(16'hFFFF));
    chk("cnt1_keep", 32'(beat_cnt1), 32'(10));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
